// File: rtl/tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : tx_scheduler_if
// Brief   : Request/handshake bundle between the protocol side, the TX FIFO
//           side, the TX control unit and the tx_scheduler.
// Revision: 1.0
// ============================================================================
interface tx_scheduler_if #(
    parameter int LEN_W = 7
);
    logic             hs_req;
    logic [1:0]       hs_type;
    logic             data_req;
    logic [LEN_W-1:0] data_len;
    logic [LEN_W-1:0] fifo_count;
    logic             tx_complete;

    logic             tx_ena;
    logic             tx_ack;
    logic             tx_nack;
    logic             stall;
    logic             ack_prep;
    logic             data_grant;
    logic             data_done;
    logic             hs_done;
    logic             timeout_err;
    logic             hs_dropped;
    logic             busy;

    // The scheduler side.
    modport master (
        input  hs_req, hs_type, data_req, data_len, fifo_count, tx_complete,
        output tx_ena, tx_ack, tx_nack, stall, ack_prep, data_grant,
               data_done, hs_done, timeout_err, hs_dropped, busy
    );

    // Requesters and TX control unit.
    modport slave (
        output hs_req, hs_type, data_req, data_len, fifo_count, tx_complete,
        input  tx_ena, tx_ack, tx_nack, stall, ack_prep, data_grant,
               data_done, hs_done, timeout_err, hs_dropped, busy
    );
endinterface
`default_nettype wire

// File: rtl/tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tx_scheduler
// Brief   : Sequences the USB TX control unit; handshakes beat data packets.
// Revision: 1.0
// ============================================================================
module tx_scheduler #(
    parameter int LEN_W      = 7,
    parameter int IPG_CYCLES = 4,
    parameter int HS_WINDOW  = 16,
    parameter int TX_TIMEOUT = 2048
) (
    input  wire logic      clk,
    input  wire logic      rst,
    tx_scheduler_if.master bus
);
    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_HS_ISSUE   = 3'd1;
    localparam logic [2:0] c_ST_HS_WAIT    = 3'd2;
    localparam logic [2:0] c_ST_DATA_ISSUE = 3'd3;
    localparam logic [2:0] c_ST_DATA_WAIT  = 3'd4;
    localparam logic [2:0] c_ST_GAP        = 3'd5;

    localparam int c_GAP_LEN = (IPG_CYCLES < 1) ? 1 : IPG_CYCLES;
    localparam int c_WIN_W   = $clog2(HS_WINDOW + 1);
    localparam int c_WD_W    = $clog2(TX_TIMEOUT + 1);
    localparam int c_GAP_W   = $clog2(c_GAP_LEN + 1);

    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(HS_WINDOW - 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TX_TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_LEN - 1);

    logic [2:0]         r_state;
    logic               r_hs_pend;
    logic [1:0]         r_hs_type;
    logic [c_WIN_W-1:0] r_win_cnt;
    logic [c_WD_W-1:0]  r_wd_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;

    logic r_tx_ena, r_tx_ack, r_tx_nack, r_stall, r_ack_prep, r_data_grant;
    logic r_data_done, r_hs_done, r_timeout_err, r_hs_dropped, r_busy;

    logic [LEN_W-1:0] w_data_len;
    logic [LEN_W-1:0] w_fifo_count;
    logic             w_hs_valid;
    logic             w_hs_rsvd;
    logic             w_launch;
    logic             w_data_go;

    assign w_data_len   = bus.data_len;
    assign w_fifo_count = bus.fifo_count;
    assign w_hs_valid   = bus.hs_req && (bus.hs_type != 2'b11);
    assign w_hs_rsvd    = bus.hs_req && (bus.hs_type == 2'b11);
    assign w_launch     = (r_state == c_ST_IDLE) && r_hs_pend;
    // A handshake arriving this very cycle still outranks a waiting data packet.
    assign w_data_go    = (r_state == c_ST_IDLE) && !r_hs_pend && !w_hs_valid &&
                          bus.data_req && (w_fifo_count >= w_data_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_hs_pend     <= 1'b0;
            r_hs_type     <= 2'b00;
            r_win_cnt     <= '0;
            r_wd_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_tx_ena      <= 1'b0;
            r_tx_ack      <= 1'b0;
            r_tx_nack     <= 1'b0;
            r_stall       <= 1'b0;
            r_ack_prep    <= 1'b0;
            r_data_grant  <= 1'b0;
            r_data_done   <= 1'b0;
            r_hs_done     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_hs_dropped  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_tx_ena      <= 1'b0;
            r_data_grant  <= 1'b0;
            r_data_done   <= 1'b0;
            r_hs_done     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_hs_dropped  <= w_hs_rsvd;

            // Latest request wins; a launch in the expiry cycle beats the drop.
            if (w_hs_valid) begin
                r_hs_pend <= 1'b1;
                r_hs_type <= bus.hs_type;
                r_win_cnt <= '0;
            end else if (w_launch) begin
                r_hs_pend <= 1'b0;
            end else if (r_hs_pend) begin
                if (r_win_cnt == c_WIN_LAST) begin
                    r_hs_pend    <= 1'b0;
                    r_hs_dropped <= 1'b1;
                end else begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_launch) begin
                        r_state    <= c_ST_HS_ISSUE;
                        r_busy     <= 1'b1;
                        r_ack_prep <= 1'b1;
                        r_tx_ack   <= (r_hs_type == 2'b00);
                        r_tx_nack  <= (r_hs_type == 2'b01);
                        r_stall    <= (r_hs_type == 2'b10);
                    end else if (w_data_go) begin
                        r_state      <= c_ST_DATA_ISSUE;
                        r_busy       <= 1'b1;
                        r_tx_ena     <= 1'b1;
                        r_data_grant <= 1'b1;
                    end
                end
                c_ST_HS_ISSUE: begin
                    r_state  <= c_ST_HS_WAIT;
                    r_wd_cnt <= '0;
                end
                c_ST_DATA_ISSUE: begin
                    r_state  <= c_ST_DATA_WAIT;
                    r_wd_cnt <= '0;
                end
                c_ST_HS_WAIT, c_ST_DATA_WAIT: begin
                    if (bus.tx_complete || (r_wd_cnt == c_WD_LAST)) begin
                        r_state    <= c_ST_GAP;
                        r_gap_cnt  <= '0;
                        r_ack_prep <= 1'b0;
                        r_tx_ack   <= 1'b0;
                        r_tx_nack  <= 1'b0;
                        r_stall    <= 1'b0;
                        if (bus.tx_complete) begin
                            r_hs_done   <= (r_state == c_ST_HS_WAIT);
                            r_data_done <= (r_state == c_ST_DATA_WAIT);
                        end else begin
                            r_timeout_err <= 1'b1;
                        end
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                c_ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_busy     <= 1'b0;
                    r_ack_prep <= 1'b0;
                    r_tx_ack   <= 1'b0;
                    r_tx_nack  <= 1'b0;
                    r_stall    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_ena      = r_tx_ena;
    assign bus.tx_ack      = r_tx_ack;
    assign bus.tx_nack     = r_tx_nack;
    assign bus.stall       = r_stall;
    assign bus.ack_prep    = r_ack_prep;
    assign bus.data_grant  = r_data_grant;
    assign bus.data_done   = r_data_done;
    assign bus.hs_done     = r_hs_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.hs_dropped  = r_hs_dropped;
    assign bus.busy        = r_busy;
endmodule
`default_nettype wire

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Sequences the USB TX control unit: decides when and what it transmits.
- Arbitrates between handshake requests (ACK/NAK/STALL) from the RX protocol side and data-packet requests from the endpoint TX FIFO side. Handshakes have strict priority.
- Drives the TX control unit's tx_ena / tx_ack / tx_nack / stall / ack_prep inputs and waits for its tx_complete.
- Enforces a handshake response window, a per-packet watchdog and an inter-packet gap.

Parameters:
- LEN_W, 7, width of data_len and fifo_count (byte counts 0..64 fit).
- IPG_CYCLES, 4, inter-packet gap in clocks after each packet end; a value of 0 is treated as 1.
- HS_WINDOW, 16, maximum clocks a captured handshake may wait for launch before it is dropped.
- TX_TIMEOUT, 2048, maximum clocks in a WAIT state before the packet is abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- hs_req  in  1  one-cycle pulse requesting a handshake.
- hs_type  in  2  handshake type, sampled with hs_req: 00 ACK, 01 NAK, 10 STALL, 11 reserved.
- data_req  in  1  level; a data packet is wanted; held until data_grant.
- data_len  in  LEN_W  payload bytes of the requested packet.
- fifo_count  in  LEN_W  bytes currently in the TX FIFO.
- tx_complete  in  1  pulse from the TX control unit at packet end.
- tx_ena  out  1  one-cycle start of a data packet.
- tx_ack / tx_nack / stall  out  1 each  handshake type select, held level.
- ack_prep  out  1  handshake launch qualifier, held level.
- data_grant  out  1  one-cycle pulse, concurrent with tx_ena.
- data_done / hs_done  out  1 each  one-cycle pulse when a packet finishes normally.
- timeout_err  out  1  one-cycle pulse when a packet is abandoned.
- hs_dropped  out  1  one-cycle pulse when a handshake is discarded.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, HS_ISSUE, HS_WAIT, DATA_ISSUE, DATA_WAIT, GAP.
- Reset (rst high at a clock edge): state IDLE; all outputs 0; handshake pending flag, type register and all counters cleared. Reset mid-packet abandons the packet silently: no done, no error pulse.
- Handshake capture (any state):
  - hs_req with a valid type sets hs_pend, latches the type, and zeroes the window counter.
  - A new hs_req while hs_pend is already set overwrites the type and restarts the window (latest wins).
  - hs_type=11: the request is ignored; hs_dropped pulses the next cycle.
- Window: while hs_pend=1 and no launch occurs, the window counter increments each clock.
  - When it reaches HS_WINDOW: hs_pend clears and hs_dropped pulses.
  - If launch and expiry fall in the same cycle, launch wins.
- IDLE arbitration, evaluated every clock in this order:
  - hs_pend=1 → HS_ISSUE.
  - else data_req=1 and fifo_count >= data_len → DATA_ISSUE (data_len=0 is legal).
  - else stay in IDLE.
- HS_ISSUE (1 cycle):
  - ack_prep=1 plus exactly one of tx_ack / tx_nack / stall, per the latched type.
  - hs_pend clears.
  - → HS_WAIT.
- HS_WAIT:
  - ack_prep and the type line stay high; the TX control unit samples them both before and after its SYNC.
  - tx_complete → GAP, with hs_done in the first GAP cycle.
- DATA_ISSUE (1 cycle): tx_ena=1 and data_grant=1 → DATA_WAIT.
- DATA_WAIT: all drive lines low; tx_complete → GAP, with data_done in the first GAP cycle.
- Watchdog:
  - The counter clears on entry to either WAIT state and increments each cycle in it.
  - Reaching TX_TIMEOUT → GAP: drive lines drop, timeout_err pulses in the first GAP cycle, no done pulse.
  - tx_complete in the same cycle as the timeout counts as normal completion.
- GAP: lasts exactly max(IPG_CYCLES,1) cycles, then → IDLE. Handshake capture and the window counter continue during GAP.
- tx_complete arriving in any state other than HS_WAIT / DATA_WAIT is ignored.
- Latency:
  - hs_req in cycle N while IDLE → ack_prep high in cycle N+2.
  - data_req with enough FIFO data in IDLE cycle N → tx_ena in cycle N+1.
- Mutual exclusion: tx_ena and ack_prep are never high together; at most one of tx_ack / tx_nack / stall is high.

Test Plan:
- Reset, then hs_req with hs_type=01 → ack_prep=tx_nack=1 from cycle +2 until tx_complete; hs_done 1 cycle later; busy low after 4 GAP cycles.
- data_req with data_len=8, fifo_count=5, then fifo_count=8 at cycle 10 → no tx_ena before cycle 10; tx_ena + data_grant for 1 cycle at cycle 11; data_done after tx_complete.
- data_req and hs_req (ACK) raised together in IDLE → handshake first; data tx_ena only after the handshake's tx_complete plus 4 GAP cycles.
- hs_req (STALL) while in DATA_WAIT with tx_complete withheld for 20 cycles → hs_dropped after 16 cycles; no stall assertion.
- DATA_WAIT with tx_complete never returned (TX_TIMEOUT=32 build) → timeout_err at watchdog expiry, no data_done, back to IDLE after GAP; then hs_type=11 → hs_dropped, no ack_prep.
- rst pulsed during HS_WAIT → next cycle all outputs 0, state IDLE, a prior pending handshake is lost; a tx_complete arriving afterwards is ignored.
